median_5x5_window_gen: RTL and testbench
========================================

// Module: median_5x5_window_gen
// PURPOSE
// Front stage of median_5x5_top_module: accepts a raster AXI4-Stream video frame and emits one
// 5x5 neighbourhood window per input pixel, centred on that pixel, for the sorting network.
// Holds KERNEL_SIZE-1 line buffers, a 5x5 register window and x/y counters, with zero padding at
// image borders. At end of frame it pads the last two rows internally, so output count = WIDTH*HEIGHT.
// PARAMETERS
// DATA_WIDTH   8     pixel width in bits
// KERNEL_SIZE  5     window side; only 5 is supported, other values are a compile-time error
// MAX_WIDTH    4096  line buffer depth; runtime WIDTH must be <= MAX_WIDTH
// DIM_BITS     13    width of the WIDTH/HEIGHT ports
// PORTS
// i_clk           in   1            clock
// i_aresetn       in   1            synchronous active-low reset
// WIDTH           in   DIM_BITS     active pixels per line, 5..MAX_WIDTH; sampled on frame start (tuser)
// HEIGHT          in   DIM_BITS     active lines per frame, >=5; sampled on frame start (tuser)
// s_axis_tdata    in   DATA_WIDTH   input pixel
// s_axis_tvalid   in   1            input pixel valid
// s_axis_tuser    in   1            first pixel of frame
// s_axis_tlast    in   1            last pixel of line (ignored for counting; mismatch sets o_sync_err)
// s_axis_tready   out  1            stage ready
// o_window        out  25*DATA_WIDTH window; element (r,c) at [(r*5+c)*DATA_WIDTH +: DATA_WIDTH]
// o_window_valid  out  1            window valid, one-cycle pulse per output pixel
// o_window_tuser  out  1            window centred on (0,0)
// o_window_tlast  out  1            window centred on x = WIDTH-1
// o_border        out  1            centre lies within 2 px of any image edge
// o_sync_err      out  1            sticky; set when tlast does not match x = WIDTH-1; cleared by reset
// BEHAVIOUR
// - Reset (i_aresetn=0 at a clock edge): all outputs 0, s_axis_tready=0, counters 0, FSM=IDLE.
//   Line buffer contents are not cleared; zero padding never reads stale data.
// - Element mapping: r=0 is row y-2, r=4 is row y+2; c=0 is column x-2. Centre is element 12.
//   Any element outside 0..WIDTH-1 x 0..HEIGHT-1 is forced to 0.
// - No downstream backpressure. Outputs change only on the cycle after an accept or a flush step.
// - FSM:
//   IDLE:  tready=1. Beats without tuser are dropped. A beat with tuser latches WIDTH/HEIGHT,
//          stores the pixel at (0,0), and moves to RUN.
//   RUN:   tready=1. Each accepted beat advances the input position (xi,yi), raster order.
//          A tuser beat arriving mid-frame aborts the frame: the pipeline is discarded, no further
//          windows are emitted for that frame, and the beat restarts as (0,0).
//          After the last pixel (WIDTH-1,HEIGHT-1) is accepted, go to FLUSH.
//   FLUSH: tready=0. One step per clock with zero pixel input, for 2*WIDTH+2 steps; then IDLE.
// - Latency: the window centred on raster index n is valid one clock after input index n+2*WIDTH+2
//   is accepted (or after the equivalent flush step). Windows for n < 2*WIDTH+2 are held until
//   then. Every frame emits exactly WIDTH*HEIGHT windows.
// - o_window_tuser and o_window_tlast are qualified by o_window_valid.
// - Line buffer: true dual-port RAM, 1-cycle read. Read address = write address = xi.
//   Read-before-write on the same address.
// - A tvalid gap stalls the window pipeline; no bubble windows are emitted.
// - WIDTH/HEIGHT changes mid-frame are ignored until the next tuser.
// TESTING
// T1 8x6 frame, pixel = 10*y+x, continuous tvalid -> 48 windows. First window centre 0, elements
//    (0..1,*) and (*,0..1) = 0, o_window_tuser=1, o_border=1. Window at (3,3): element 0=11,
//    element 24=55, o_border=0.
// T2 T1 with tvalid toggling 1010 -> identical window sequence. tready falls for exactly 2*8+2=18
//    cycles after the last accept.
// T3 Beats before the first tuser (tdata=0xFF) -> dropped; first window centre matches the tuser
//    pixel. o_window_tlast is set on every 8th window.
// T4 Second tuser after 20 pixels of an 8x6 frame -> old frame aborted. New frame emits 48 correct
//    windows, the first with o_window_tuser=1.
// T5 i_aresetn low for 1 cycle mid-FLUSH -> next cycle all outputs 0, tready=0, then tready=1 in IDLE.
//    The next frame is correct.
// T6 Back-to-back 4096x5 frames, tlast missing at x=4095 -> o_sync_err=1 (sticky).
//    Window count per frame is still 20480.

Source files
------------

// File: rtl/median_5x5_window_gen.sv
// 5x5 neighbourhood window generator for the median filter front end.
// Four cascaded line buffers feed a 5x5 register window; border taps are zeroed.
module median_5x5_window_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int MAX_WIDTH   = 4096,
  parameter int DIM_BITS    = 13
) (
  input  logic                       i_clk,
  input  logic                       i_aresetn,
  input  logic [DIM_BITS-1:0]        WIDTH,
  input  logic [DIM_BITS-1:0]        HEIGHT,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [25*DATA_WIDTH-1:0]   o_window,
  output logic                       o_window_valid,
  output logic                       o_window_tuser,
  output logic                       o_window_tlast,
  output logic                       o_border,
  output logic                       o_sync_err
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(MAX_WIDTH);
  localparam int CW = DIM_BITS + 1;

  if (KERNEL_SIZE != 5) begin : g_bad_kernel
    $error("median_5x5_window_gen: only KERNEL_SIZE=5");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [DIM_BITS-1:0] w_q, h_q;
  logic [DIM_BITS-1:0] xi, yi;
  logic [DIM_BITS-1:0] xc, yc;
  logic [CW-1:0]       fill, flush_cnt, fill_goal;

  logic          accept, new_frame, abort;
  logic          step, last_px, flush_done, eol;
  logic [DW-1:0] pix;
  logic [AW-1:0] rd_addr;

  logic          s1_valid;
  logic [DW-1:0] s1_pix;
  logic [AW-1:0] s1_addr;

  logic [4*DW-1:0] rd_bus;
  logic [4*DW-1:0] wr_bus;

  logic [DW-1:0] col [5];
  logic [DW-1:0] raw [5][5];
  logic [DW-1:0] sh  [5][5];

  logic [4:0]         row_ok, col_ok;
  logic [25*DW-1:0]   win_nxt;
  logic               border, emit;

  assign accept    = s_axis_tvalid & s_axis_tready;
  assign new_frame = accept & s_axis_tuser;
  assign abort     = new_frame & (state == RUN);
  assign step      = (accept & ((state == RUN) | s_axis_tuser))
                   | (state == FLUSH);
  assign pix       = (state == FLUSH) ? '0 : s_axis_tdata;
  assign rd_addr   = new_frame ? '0 : xi[AW-1:0];

  assign fill_goal  = {w_q, 1'b0} + CW'(2);
  assign flush_done = (flush_cnt == fill_goal - CW'(1));
  assign last_px    = (xi == w_q - DIM_BITS'(1))
                    & (yi == h_q - DIM_BITS'(1));
  assign eol        = new_frame ? (WIDTH == DIM_BITS'(1))
                                : (xi == w_q - DIM_BITS'(1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (new_frame) state_nxt = RUN;
      RUN:   if (accept && !s_axis_tuser && last_px)
               state_nxt = FLUSH;
      FLUSH: if (flush_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      w_q           <= '0;
      h_q           <= '0;
      xi            <= '0;
      yi            <= '0;
      flush_cnt     <= '0;
      o_sync_err    <= 1'b0;
    end else begin
      state         <= state_nxt;
      s_axis_tready <= (state_nxt != FLUSH);
      if (new_frame) begin
        w_q <= WIDTH;
        h_q <= HEIGHT;
        xi  <= DIM_BITS'(1);
        yi  <= '0;
      end else if (step) begin
        if (xi == w_q - DIM_BITS'(1)) begin
          xi <= '0;
          yi <= yi + DIM_BITS'(1);
        end else begin
          xi <= xi + DIM_BITS'(1);
        end
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + CW'(1);
      else                flush_cnt <= '0;
      if (step && (state != FLUSH) && (s_axis_tlast != eol))
        o_sync_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) s1_valid <= 1'b0;
    else            s1_valid <= step;
    s1_pix  <= pix;
    s1_addr <= rd_addr;
  end

  // buffer j holds row y-1-j; each beat shifts the column down one buffer
  assign wr_bus = {rd_bus[3*DW-1:0], s1_pix};

  for (genvar j = 0; j < 4; j++) begin : g_lb
    logic [DW-1:0] mem [MAX_WIDTH];
    logic [DW-1:0] q;
    always_ff @(posedge i_clk) begin
      q <= mem[rd_addr];
      if (s1_valid) mem[s1_addr] <= wr_bus[j*DW +: DW];
    end
    assign rd_bus[j*DW +: DW] = q;
  end

  always_comb begin
    col[4] = s1_pix;
    for (int r = 0; r < 4; r++)
      col[r] = rd_bus[(3-r)*DW +: DW];
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++)
        sh[r][c] = raw[r][c+1];
      sh[r][4] = col[r];
    end
  end

  always_ff @(posedge i_clk) begin
    if (s1_valid) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          raw[r][c] <= sh[r][c];
    end
  end

  always_comb begin
    col_ok[0] = (xc >= DIM_BITS'(2));
    col_ok[1] = (xc >= DIM_BITS'(1));
    col_ok[2] = 1'b1;
    col_ok[3] = (xc < w_q - DIM_BITS'(1));
    col_ok[4] = (xc < w_q - DIM_BITS'(2));
    row_ok[0] = (yc >= DIM_BITS'(2));
    row_ok[1] = (yc >= DIM_BITS'(1));
    row_ok[2] = 1'b1;
    row_ok[3] = (yc < h_q - DIM_BITS'(1));
    row_ok[4] = (yc < h_q - DIM_BITS'(2));
    border = ~(col_ok[0] & col_ok[4]
             & row_ok[0] & row_ok[4]);
    win_nxt = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (row_ok[r] && col_ok[c])
          win_nxt[(r*5+c)*DW +: DW] = sh[r][c];
  end

  // first 2*WIDTH+2 steps of a frame only prime the window
  assign emit = s1_valid & (fill == fill_goal) & ~abort;

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      fill <= '0;
      xc   <= '0;
      yc   <= '0;
    end else if (new_frame) begin
      fill <= '0;
      xc   <= '0;
      yc   <= '0;
    end else if (s1_valid) begin
      if (fill != fill_goal) begin
        fill <= fill + CW'(1);
      end else if (xc == w_q - DIM_BITS'(1)) begin
        xc <= '0;
        yc <= yc + DIM_BITS'(1);
      end else begin
        xc <= xc + DIM_BITS'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_window_tuser <= 1'b0;
      o_window_tlast <= 1'b0;
      o_border       <= 1'b0;
    end else begin
      o_window_valid <= emit;
      o_window_tuser <= emit & (xc == '0) & (yc == '0);
      o_window_tlast <= emit & (xc == w_q - DIM_BITS'(1));
      if (emit) begin
        o_window <= win_nxt;
        o_border <= border;
      end
    end
  end

endmodule

// File: tb/tb_median_5x5_window_gen.sv
// Directed bench for median_5x5_window_gen.
// Expected windows come from an image-level model checked on every valid pulse.
module tb_median_5x5_window_gen;

  localparam int DW = 8;
  localparam int DB = 13;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DB-1:0] width, height;
  logic [DW-1:0] tdata;
  logic          tvalid, tuser, tlast, tready;
  logic [25*DW-1:0] win;
  logic          wv, wu, wl, bord, serr;

  always #5 clk = ~clk;

  median_5x5_window_gen #(
    .DATA_WIDTH(8), .KERNEL_SIZE(5),
    .MAX_WIDTH(4096), .DIM_BITS(13)
  ) dut (
    .i_clk(clk), .i_aresetn(rstn),
    .WIDTH(width), .HEIGHT(height),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .s_axis_tready(tready),
    .o_window(win), .o_window_valid(wv),
    .o_window_tuser(wu), .o_window_tlast(wl),
    .o_border(bord), .o_sync_err(serr)
  );

  typedef struct {
    int mode; int w; int h; int xc; int yc; int cap;
  } exp_t;

  exp_t q[$];
  int vecs = 0;
  int errs = 0;
  int wins = 0;
  logic [199:0] cap_win [4];
  logic [2:0]   cap_fl  [4];

  function automatic logic [7:0] pixel(int mode, int x, int y);
    case (mode)
      0:       return 8'(10*y + x);
      1:       return 8'(x*7 + y*13 + 3);
      default: return 8'(x ^ (y*37));
    endcase
  endfunction

  function automatic logic [199:0] model_win(exp_t e);
    logic [199:0] w;
    int xx, yy;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        xx = e.xc + c - 2;
        yy = e.yc + r - 2;
        if (xx >= 0 && xx < e.w && yy >= 0 && yy < e.h)
          w[(r*5+c)*8 +: 8] = pixel(e.mode, xx, yy);
      end
    return w;
  endfunction

  function automatic logic [2:0] model_fl(exp_t e);
    logic b;
    b = !(e.xc >= 2 && e.yc >= 2 &&
          e.xc + 2 < e.w && e.yc + 2 < e.h);
    return {e.xc == 0 && e.yc == 0, e.xc == e.w - 1, b};
  endfunction

  task automatic check(string nm, logic [199:0] act,
                       logic [199:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (wv === 1'b1) begin
      wins++;
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL spurious_window: got valid, want none");
      end else begin
        e = q.pop_front();
        check("window", win, model_win(e));
        check("flags", 200'({wu, wl, bord}), 200'(model_fl(e)));
        if (e.cap != 0) begin
          cap_win[e.cap] = win;
          cap_fl[e.cap]  = {wu, wl, bord};
        end
      end
    end
  end

  task automatic expect_frame(int mode, int w, int h,
                              int n, int cap0);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{mode, w, h, i % w, i / w, (i == 0) ? cap0 : 0};
      q.push_back(e);
    end
  endtask

  task automatic beat(logic [7:0] d, logic u, logic l);
    int t;
    @(negedge clk);
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    t = 0;
    while (!tready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      vecs++;
      errs++;
      $display("FAIL beat_timeout: got no tready, want tready");
    end
    @(posedge clk);
  endtask

  task automatic idle(int n);
    @(negedge clk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(int mode, int w, int h, bit gap,
                            bit good, int npix);
    int x, y;
    for (int i = 0; i < npix; i++) begin
      x = i % w;
      y = i / w;
      beat(pixel(mode, x, y), i == 0, good && (x == w - 1));
      if (gap && i != npix - 1) idle(1);
    end
  endtask

  task automatic wait_idle(output int low);
    low = 0;
    @(negedge clk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    while (!tready && low < 10000) begin
      low++;
      @(negedge clk);
    end
    if (low >= 10000) begin
      vecs++;
      errs++;
      $display("FAIL flush_timeout: got tready low, want high");
    end
    @(posedge clk);
  endtask

  task automatic drain(string nm);
    repeat (4) @(posedge clk);
    check(nm, 200'(q.size()), 200'(0));
  endtask

  initial begin
    int low, w0;
    rstn = 1'b0; width = 8; height = 6;
    tdata = '0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tready", 200'(tready), 200'(0));
    check("rst_valid", 200'(wv), 200'(0));
    check("rst_window", win, 200'(0));
    check("rst_flags", 200'({wu, wl, bord, serr}), 200'(0));
    rstn = 1'b1;
    @(posedge clk);

    // T1: 8x6 continuous
    expect_frame(0, 8, 6, 48, 1);
    q[27].cap = 2;
    send_frame(0, 8, 6, 0, 1, 48);
    wait_idle(low);
    check("t1_tready_low", 200'(low), 200'(18));
    drain("t1_count");
    check("t1_w0_rows01", 200'(cap_win[1][79:0]), 200'(0));
    check("t1_w0_e13", 200'(cap_win[1][13*8 +: 8]), 200'(1));
    check("t1_w0_e18", 200'(cap_win[1][18*8 +: 8]), 200'(11));
    check("t1_w0_e24", 200'(cap_win[1][24*8 +: 8]), 200'(22));
    check("t1_w0_flags", 200'(cap_fl[1]), 200'(3'b101));
    check("t1_w33_e0", 200'(cap_win[2][7:0]), 200'(11));
    check("t1_w33_e12", 200'(cap_win[2][12*8 +: 8]), 200'(33));
    check("t1_w33_e24", 200'(cap_win[2][24*8 +: 8]), 200'(55));
    check("t1_w33_flags", 200'(cap_fl[2]), 200'(3'b000));
    check("t1_sync_err", 200'(serr), 200'(0));

    // T2: tvalid toggling
    expect_frame(0, 8, 6, 48, 0);
    send_frame(0, 8, 6, 1, 1, 48);
    wait_idle(low);
    check("t2_tready_low", 200'(low), 200'(18));
    drain("t2_count");

    // T3: junk before tuser
    repeat (3) beat(8'hFF, 1'b0, 1'b0);
    expect_frame(1, 8, 6, 48, 0);
    send_frame(1, 8, 6, 0, 1, 48);
    wait_idle(low);
    drain("t3_count");

    // T4: abort after 20 pixels
    expect_frame(0, 8, 6, 2, 0);
    send_frame(0, 8, 6, 0, 1, 20);
    idle(3);
    expect_frame(1, 8, 6, 48, 3);
    send_frame(1, 8, 6, 0, 1, 48);
    wait_idle(low);
    drain("t4_count");
    check("t4_first_flags", 200'(cap_fl[3]), 200'(3'b101));

    // T5: reset in FLUSH
    expect_frame(2, 8, 6, 31, 0);
    send_frame(2, 8, 6, 0, 1, 48);
    repeat (3) @(negedge clk);
    tvalid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_tready", 200'(tready), 200'(0));
    check("t5_rst_valid", 200'(wv), 200'(0));
    check("t5_rst_window", win, 200'(0));
    check("t5_rst_flags", 200'({wu, wl, bord, serr}), 200'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("t5_idle_tready", 200'(tready), 200'(1));
    @(posedge clk);
    check("t5_partial", 200'(q.size()), 200'(0));
    expect_frame(0, 8, 6, 48, 0);
    send_frame(0, 8, 6, 0, 1, 48);
    wait_idle(low);
    drain("t5_count");
    check("t5_sync_err", 200'(serr), 200'(0));

    // T6: wide frames without tlast
    width = 4096; height = 5;
    w0 = wins;
    expect_frame(1, 4096, 5, 20480, 0);
    send_frame(1, 4096, 5, 0, 0, 20480);
    wait_idle(low);
    check("t6_tready_low", 200'(low), 200'(8194));
    check("t6_sync_err1", 200'(serr), 200'(1));
    drain("t6_count1");
    check("t6_wins1", 200'(wins - w0), 200'(20480));
    w0 = wins;
    expect_frame(2, 4096, 5, 20480, 0);
    send_frame(2, 4096, 5, 0, 0, 20480);
    wait_idle(low);
    drain("t6_count2");
    check("t6_wins2", 200'(wins - w0), 200'(20480));
    check("t6_sync_err2", 200'(serr), 200'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
